// File: rtl/vector_writeback_unit.sv
// ---------------------------------------------------------------------------
// vector_writeback_unit
//
// Captures the vector function unit result on the single FINISHED cycle,
// merges it into the old destination contents under mask (vm/v0) and tail
// (vl) rules, LANE_SIZE elements per cycle (LANE_SIZE*8 bits per cycle for
// mask-producing ops), then hands the merged register to the VRF write port
// over a valid/ready handshake.
//
// Optional feature macro: VECTOR_WB_TAIL_AGNOSTIC_EN
//   defined   -> tail and masked-off elements are written all-ones
//   undefined -> tail and masked-off elements keep vd_old (undisturbed)
//
// Ports:
//   clk, rst (async, active low), rdy_in (global stall, 0 = hold everything)
//   vector_alu_status  function unit status (NOP/WORKING/FINISHED)
//   result, is_mask, cur_vsew, vl, vm, mask, vd_index, vd_old
//                      operands latched at FINISHED
//   vrf_wr_valid/ready/index/data  VRF write handshake
//   wb_busy            high whenever not IDLE
//   wb_done            one-cycle pulse on write handshake
//   overrun_err        sticky: FINISHED while busy, or illegal cur_vsew
// ---------------------------------------------------------------------------
`ifndef VEC_ALU_NOP
`define VEC_ALU_NOP 2'b00
`endif
`ifndef VEC_ALU_WORKING
`define VEC_ALU_WORKING 2'b01
`endif
`ifndef VEC_ALU_FINISHED
`define VEC_ALU_FINISHED 2'b10
`endif
`ifndef ONE_BYTE
`define ONE_BYTE 3'd0
`endif
`ifndef EIGHT_BYTE
`define EIGHT_BYTE 3'd3
`endif

module vector_writeback_unit #(
   parameter int VECTOR_SIZE     = 8,
   parameter int DATA_LEN        = 32,
   parameter int LANE_SIZE       = 2,
   parameter int VREG_INDEX_SIZE = 5
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              rdy_in,
   input  logic [1:0]                        vector_alu_status,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0]   result,
   input  logic                              is_mask,
   input  logic [2:0]                        cur_vsew,
   input  logic [DATA_LEN-1:0]               vl,
   input  logic                              vm,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0]   mask,
   input  logic [VREG_INDEX_SIZE-1:0]        vd_index,
   input  logic [VECTOR_SIZE*DATA_LEN-1:0]   vd_old,
   output logic                              vrf_wr_valid,
   input  logic                              vrf_wr_ready,
   output logic [VREG_INDEX_SIZE-1:0]        vrf_wr_index,
   output logic [VECTOR_SIZE*DATA_LEN-1:0]   vrf_wr_data,
   output logic                              wb_busy,
   output logic                              wb_done,
   output logic                              overrun_err
);

   localparam int VLEN = VECTOR_SIZE * DATA_LEN;
   // Element index width: must hold VLEN itself (mask-op element count).
   localparam int EW   = $clog2(VLEN) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [VLEN-1:0]            result_reg;
   logic [VLEN-1:0]            mask_reg;
   logic [VLEN-1:0]            merge_buf_reg;
   logic [VLEN-1:0]            merge_next;
   logic                       is_mask_reg;
   logic [1:0]                 sew_reg;
   logic [DATA_LEN-1:0]        vl_reg;
   logic                       vm_reg;
   logic [VREG_INDEX_SIZE-1:0] vd_index_reg;
   logic [EW-1:0]              elem_idx_reg;

   logic          finished;
   logic          capture;
   logic          handshake;
   logic          merge_last;
   logic [EW-1:0] ne;
   logic [EW-1:0] evl;
   logic [EW-1:0] step;
   logic [EW-1:0] window_end;

   assign finished     = (vector_alu_status == `VEC_ALU_FINISHED);
   assign wb_busy      = (state_reg != IDLE);
   assign vrf_wr_index = vd_index_reg;
   assign vrf_wr_data  = merge_buf_reg;

   // Element count, effective length and per-cycle step for the latched op.
   always_comb begin
      if (is_mask_reg) begin
         ne   = EW'(VLEN);
         step = EW'(LANE_SIZE * 8);
      end else begin
         ne   = EW'(VLEN / 8) >> sew_reg;
         step = EW'(LANE_SIZE);
      end
      if (vl_reg < DATA_LEN'(ne))
         evl = EW'(vl_reg);
      else
         evl = ne;
   end

   assign window_end = elem_idx_reg + step;
   assign merge_last = (window_end >= ne);

   // Per-bit merge: each bit works out which element it belongs to for the
   // current SEW, then updates only if that element is in this cycle's window.
   for (genvar gi = 0; gi < VLEN; gi++) begin : g_bit
      logic [EW-1:0] elem;
      logic          mbit;
      logic          in_win;
      logic          take;
      logic          fill;

      always_comb begin
         elem = EW'(gi);
         mbit = mask_reg[gi];
         if (!is_mask_reg) begin
            case (sew_reg)
               2'd0:    begin elem = EW'(gi / 8);  mbit = mask_reg[gi / 8];  end
               2'd1:    begin elem = EW'(gi / 16); mbit = mask_reg[gi / 16]; end
               2'd2:    begin elem = EW'(gi / 32); mbit = mask_reg[gi / 32]; end
               default: begin elem = EW'(gi / 64); mbit = mask_reg[gi / 64]; end
            endcase
         end
      end

      assign in_win = (elem >= elem_idx_reg) && (elem < window_end);
      assign take   = (elem < evl) && (vm_reg || mbit);
`ifdef VECTOR_WB_TAIL_AGNOSTIC_EN
      assign fill   = 1'b1;
`else
      assign fill   = merge_buf_reg[gi];
`endif
      assign merge_next[gi] = in_win ? (take ? result_reg[gi] : fill)
                                     : merge_buf_reg[gi];
   end

   // FSM next-state and control strobes.
   always_comb begin
      state_next = state_reg;
      capture    = 1'b0;
      handshake  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (rdy_in && finished) begin
               capture    = 1'b1;
               state_next = (vl == '0) ? WRITE : MERGE;
            end
         end
         MERGE: begin
            if (rdy_in && merge_last)
               state_next = WRITE;
         end
         WRITE: begin
            // Ready is only consumed while the global stall is released.
            if (rdy_in && vrf_wr_valid && vrf_wr_ready) begin
               handshake  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         result_reg    <= '0;
         mask_reg      <= '0;
         merge_buf_reg <= '0;
         is_mask_reg   <= 1'b0;
         sew_reg       <= 2'd0;
         vl_reg        <= '0;
         vm_reg        <= 1'b0;
         vd_index_reg  <= '0;
         elem_idx_reg  <= '0;
         vrf_wr_valid  <= 1'b0;
         wb_done       <= 1'b0;
         overrun_err   <= 1'b0;
      end else if (rdy_in) begin
         wb_done <= handshake;
         if (finished && state_reg != IDLE)
            overrun_err <= 1'b1;
         if (capture) begin
            result_reg    <= result;
            mask_reg      <= mask;
            merge_buf_reg <= vd_old;
            is_mask_reg   <= is_mask;
            // Illegal SEW is flagged and then handled as 64-bit elements.
            if (cur_vsew > `EIGHT_BYTE) begin
               sew_reg     <= 2'd3;
               overrun_err <= 1'b1;
            end else begin
               sew_reg     <= cur_vsew[1:0];
            end
            vl_reg        <= vl;
            vm_reg        <= vm;
            vd_index_reg  <= vd_index;
            elem_idx_reg  <= '0;
            if (vl == '0)
               vrf_wr_valid <= 1'b1;
         end
         if (state_reg == MERGE) begin
            merge_buf_reg <= merge_next;
            elem_idx_reg  <= window_end;
            if (merge_last)
               vrf_wr_valid <= 1'b1;
         end
         if (handshake)
            vrf_wr_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_vector_writeback_unit
//
// Self-checking bench: directed cases plus randomized transactions compared
// against an element-level reference model of the mask/tail merge rules and
// the expected merge latency.
// ---------------------------------------------------------------------------
module tb_vector_writeback_unit;

   localparam int VLEN = 256;
   localparam logic [1:0] ST_NOP = 2'b00;
   localparam logic [1:0] ST_FIN = 2'b10;

   logic            clk = 1'b0;
   logic            rst;
   logic            rdy_in;
   logic [1:0]      vector_alu_status;
   logic [VLEN-1:0] result;
   logic            is_mask;
   logic [2:0]      cur_vsew;
   logic [31:0]     vl;
   logic            vm;
   logic [VLEN-1:0] mask;
   logic [4:0]      vd_index;
   logic [VLEN-1:0] vd_old;
   logic            vrf_wr_valid;
   logic            vrf_wr_ready;
   logic [4:0]      vrf_wr_index;
   logic [VLEN-1:0] vrf_wr_data;
   logic            wb_busy;
   logic            wb_done;
   logic            overrun_err;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   n_txn    = 0;
   logic ovr_exp  = 1'b0;

   always #5 clk = ~clk;

   vector_writeback_unit dut (
      .clk               (clk),
      .rst               (rst),
      .rdy_in            (rdy_in),
      .vector_alu_status (vector_alu_status),
      .result            (result),
      .is_mask           (is_mask),
      .cur_vsew          (cur_vsew),
      .vl                (vl),
      .vm                (vm),
      .mask              (mask),
      .vd_index          (vd_index),
      .vd_old            (vd_old),
      .vrf_wr_valid      (vrf_wr_valid),
      .vrf_wr_ready      (vrf_wr_ready),
      .vrf_wr_index      (vrf_wr_index),
      .vrf_wr_data       (vrf_wr_data),
      .wb_busy           (wb_busy),
      .wb_done           (wb_done),
      .overrun_err       (overrun_err)
   );

   task automatic check(input string tag, input logic [VLEN-1:0] got,
                        input logic [VLEN-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [VLEN-1:0] rand_vec();
      logic [VLEN-1:0] v;
      for (int i = 0; i < VLEN / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Element counts from the architectural rules: data ops have
   // VLEN/(8<<sew) elements, mask ops VLEN 1-bit elements.
   function automatic int ref_ne(input logic [2:0] sew, input logic mop);
      int s;
      s = (sew > 3) ? 3 : int'(sew);
      return mop ? VLEN : VLEN / (8 << s);
   endfunction

   function automatic int ref_lat(input logic [2:0] sew, input logic mop,
                                  input logic [31:0] vlv);
      int ne, st;
      ne = ref_ne(sew, mop);
      st = mop ? 16 : 2;
      return (vlv == 0) ? 0 : (ne + st - 1) / st;
   endfunction

   function automatic logic [VLEN-1:0] ref_merge(
      input logic [2:0] sew, input logic mop, input logic [31:0] vlv,
      input logic vmv, input logic [VLEN-1:0] res, input logic [VLEN-1:0] msk,
      input logic [VLEN-1:0] old);
      logic [VLEN-1:0] o;
      int ne, w, evl;
      bit take;
      ne  = ref_ne(sew, mop);
      w   = VLEN / ne;
      evl = (longint'(vlv) < longint'(ne)) ? int'(vlv) : ne;
      o   = old;
      if (vlv == 0) return old;
      for (int i = 0; i < ne; i++) begin
         take = (i < evl) && (vmv || msk[i]);
         for (int b = 0; b < w; b++) begin
            if (take) o[i*w + b] = res[i*w + b];
`ifdef VECTOR_WB_TAIL_AGNOSTIC_EN
            else      o[i*w + b] = 1'b1;
`endif
         end
      end
      return o;
   endfunction

   // One full transaction: FINISHED pulse, optional rdy_in stall at the start
   // of MERGE, optional ready back-pressure in WRITE.
   task automatic run_op(input logic [2:0] sew, input logic mop,
                         input logic [31:0] vlv, input logic vmv,
                         input logic [VLEN-1:0] res, input logic [VLEN-1:0] msk,
                         input logic [VLEN-1:0] old, input logic [4:0] idx,
                         input int stall, input int rdly);
      logic [VLEN-1:0] exp;
      int lat, cnt, exp_cnt;
      exp = ref_merge(sew, mop, vlv, vmv, res, msk, old);
      lat = ref_lat(sew, mop, vlv);
      exp_cnt = (lat == 0) ? 0 : lat + stall;

      vector_alu_status = ST_FIN;
      cur_vsew = sew; is_mask = mop; vl = vlv; vm = vmv;
      result = res; mask = msk; vd_old = old; vd_index = idx;
      vrf_wr_ready = 1'b0;
      tick();
      if (sew > 3) ovr_exp = 1'b1;
      vector_alu_status = ST_NOP;
      // Scramble operands: the unit must work from its latched copies.
      result = rand_vec(); mask = rand_vec(); vd_old = rand_vec();
      vl = $urandom; vm = 1'($urandom); is_mask = 1'($urandom);
      cur_vsew = 3'($urandom); vd_index = 5'($urandom);

      cnt = 0;
      rdy_in = (stall > 0) ? 1'b0 : 1'b1;
      while (!vrf_wr_valid && cnt < 300) begin
         tick();
         cnt++;
         if (cnt >= stall) rdy_in = 1'b1;
      end
      rdy_in = 1'b1;
      check("merge_cycles", cnt, exp_cnt);
      check("busy_in_write", wb_busy, 1'b1);
      check("wr_index", vrf_wr_index, idx);
      check("wr_data", vrf_wr_data, exp);

      for (int d = 0; d < rdly; d++) tick();
      if (rdly > 0) begin
         check("valid_held", vrf_wr_valid, 1'b1);
         check("data_held", vrf_wr_data, exp);
      end

      vrf_wr_ready = 1'b1;
      tick();
      check("wb_done_pulse", wb_done, 1'b1);
      check("valid_cleared", vrf_wr_valid, 1'b0);
      check("busy_cleared", wb_busy, 1'b0);
      vrf_wr_ready = 1'b0;
      tick();
      check("wb_done_single", wb_done, 1'b0);
      check("overrun", overrun_err, ovr_exp);
      n_txn++;
      $display("txn %0d: sew=%0d mask_op=%0b vl=%0d vm=%0b idx=%0d stall=%0d rdly=%0d merge_cycles=%0d",
               n_txn, sew, mop, vlv, vmv, idx, stall, rdly, cnt);
   endtask

   initial begin
      logic [VLEN-1:0] r, o, m, d0;
      logic [2:0]  sew;
      logic        mop;
      logic [31:0] vlv;
      int          ne, vcount;

      rst = 1'b0; rdy_in = 1'b1; vector_alu_status = ST_NOP;
      result = '0; is_mask = 1'b0; cur_vsew = 3'd0; vl = '0; vm = 1'b0;
      mask = '0; vd_index = '0; vd_old = '0; vrf_wr_ready = 1'b0;
      tick(); tick();
      check("rst_valid", vrf_wr_valid, 1'b0);
      check("rst_busy", wb_busy, 1'b0);
      check("rst_done", wb_done, 1'b0);
      check("rst_overrun", overrun_err, 1'b0);
      check("rst_data", vrf_wr_data, '0);
      check("rst_index", vrf_wr_index, '0);
      rst = 1'b1;
      tick();

      // SEW32, vl=8, unmasked, words 1..8 over 0xAAAAAAAA.
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'(i + 1);
      o = {8{32'hAAAA_AAAA}};
      run_op(3'd2, 1'b0, 32'd8, 1'b1, r, '0, o, 5'd3, 0, 0);

      // SEW8, vl=5 tail handling.
      run_op(3'd0, 1'b0, 32'd5, 1'b1, {32{8'h11}}, '0, '0, 5'd7, 0, 0);

      // SEW16, vl=16, masked by v0 = 0x5555.
      m = '0; m[15:0] = 16'h5555;
      run_op(3'd1, 1'b0, 32'd16, 1'b0, {16{16'h1234}}, m, {16{16'hBEEF}},
             5'd9, 0, 1);

      // Mask op, vl=10: 16 merge cycles.
      run_op(3'd0, 1'b1, 32'd10, 1'b1, {VLEN{1'b1}}, '0, '0, 5'd1, 0, 0);

      // vl=0: straight to WRITE, data unchanged.
      run_op(3'd2, 1'b0, 32'd0, 1'b1, rand_vec(), '0, rand_vec(), 5'd30, 0, 0);

      // Randomized transactions.
      for (int t = 0; t < 24; t++) begin
         mop = ($urandom_range(0, 4) == 0);
         sew = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7))
                                           : 3'($urandom_range(0, 3));
         ne  = ref_ne(sew, mop);
         case ($urandom_range(0, 3))
            0:       vlv = 32'd0;
            1:       vlv = 32'($urandom_range(1, ne));
            2:       vlv = 32'(ne);
            default: vlv = $urandom;
         endcase
         run_op(sew, mop, vlv, 1'($urandom), rand_vec(), rand_vec(), rand_vec(),
                5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end

      // Back-pressure with a second FINISHED during WRITE.
      vector_alu_status = ST_FIN; cur_vsew = 3'd2; is_mask = 1'b0;
      vl = 32'd8; vm = 1'b1; result = rand_vec(); vd_old = rand_vec();
      vd_index = 5'd12; vrf_wr_ready = 1'b0;
      tick();
      vector_alu_status = ST_NOP;
      vcount = 0;
      while (!vrf_wr_valid && vcount < 50) begin tick(); vcount++; end
      check("bp_reach_write", vrf_wr_valid, 1'b1);
      d0 = vrf_wr_data;
      for (int c = 0; c < 5; c++) begin
         vector_alu_status = (c == 2) ? ST_FIN : ST_NOP;
         tick();
         check("bp_valid_stable", vrf_wr_valid, 1'b1);
         check("bp_data_stable", vrf_wr_data, d0);
      end
      vector_alu_status = ST_NOP;
      ovr_exp = 1'b1;
      check("bp_overrun", overrun_err, 1'b1);
      // Ready while rdy_in=0 must not be consumed.
      rdy_in = 1'b0; vrf_wr_ready = 1'b1;
      tick(); tick();
      check("stall_valid_hold", vrf_wr_valid, 1'b1);
      check("stall_no_done", wb_done, 1'b0);
      rdy_in = 1'b1;
      tick();
      check("bp_done", wb_done, 1'b1);
      vrf_wr_ready = 1'b0;
      vcount = 0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (wb_done) vcount++;
      end
      check("bp_single_done", vcount, 0);
      n_txn++;
      $display("txn %0d: backpressure + overrun, data=%h", n_txn, d0);

      // Reset in the middle of MERGE.
      vector_alu_status = ST_FIN; cur_vsew = 3'd0; is_mask = 1'b0;
      vl = 32'd32; vm = 1'b1; result = rand_vec(); vd_old = rand_vec();
      vd_index = 5'd21; vrf_wr_ready = 1'b1;
      tick();
      vector_alu_status = ST_NOP;
      tick(); tick(); tick();
      check("pre_rst_busy", wb_busy, 1'b1);
      #2 rst = 1'b0;
      #1;
      ovr_exp = 1'b0;
      check("arst_valid", vrf_wr_valid, 1'b0);
      check("arst_busy", wb_busy, 1'b0);
      check("arst_done", wb_done, 1'b0);
      check("arst_overrun", overrun_err, 1'b0);
      check("arst_data", vrf_wr_data, '0);
      check("arst_index", vrf_wr_index, '0);
      tick();
      rst = 1'b1;
      vcount = 0;
      for (int c = 0; c < 24; c++) begin
         tick();
         if (vrf_wr_valid || wb_done) vcount++;
      end
      check("no_write_after_rst", vcount, 0);
      n_txn++;
      $display("txn %0d: async reset mid-MERGE", n_txn);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_writeback_unit.md
Name: vector_writeback_unit

Overview:
- Sits directly downstream of the vector function unit and upstream of the vector register file (VRF) write port.
- Captures the function unit's packed result in the single cycle its status reads FINISHED.
- Merges the result element-by-element with the old destination contents, applying the mask (vm/v0) and tail rules (vl). Mask-producing ops are merged at bit granularity.
- Delivers the merged register to the VRF over a valid/ready handshake and signals completion to issue.

Parameters:
- VECTOR_SIZE, 8, number of 32-bit words per vector register (VLEN = VECTOR_SIZE*DATA_LEN = 256).
- DATA_LEN, 32, word width in bits.
- LANE_SIZE, 2, elements merged per cycle in MERGE.
- VREG_INDEX_SIZE, 5, width of a vector register index.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global stall; when 0 all state and outputs hold.
- vector_alu_status  input  2  function unit status, `VEC_ALU_NOP/`VEC_ALU_WORKING/`VEC_ALU_FINISHED.
- result  input  VECTOR_SIZE*DATA_LEN  packed function unit result.
- is_mask  input  1  result is a 1-bit-per-element mask.
- cur_vsew  input  3  effective result SEW (`ONE_BYTE..`EIGHT_BYTE = 0..3).
- vl  input  DATA_LEN  active vector length.
- vm  input  1  1 = unmasked.
- mask  input  VECTOR_SIZE*DATA_LEN  v0 contents.
- vd_index  input  VREG_INDEX_SIZE  destination register.
- vd_old  input  VECTOR_SIZE*DATA_LEN  current vd contents.
- vrf_wr_valid  output  1  write request.
- vrf_wr_ready  input  1  VRF accepts the write.
- vrf_wr_index  output  VREG_INDEX_SIZE  write target.
- vrf_wr_data  output  VECTOR_SIZE*DATA_LEN  merged data.
- wb_busy  output  1  1 whenever state != IDLE.
- wb_done  output  1  one-cycle pulse on handshake completion.
- overrun_err  output  1  sticky; FINISHED seen while busy.

Behaviour:
- Reset (rst=0, async): state=IDLE, all outputs 0, internal buffers 0, elem_idx=0. Reset mid-operation discards the transfer; no partial write is issued.
- States: IDLE -> MERGE -> WRITE -> IDLE.
- IDLE: when vector_alu_status==`VEC_ALU_FINISHED and rdy_in:
  - Latch result, is_mask, cur_vsew, vl, vm, mask, vd_index and vd_old (vd_old is the merge buffer).
  - Clear elem_idx and go to MERGE.
- FINISHED lasts exactly one cycle upstream, so capture is single-shot.
- MERGE, per cycle, element indices elem_idx..elem_idx+LANE_SIZE-1:
  - Element count per register NE = VLEN/(8<<vsew) for data ops, or VLEN for mask ops. Effective length EVL = min(vl, NE).
  - For element i < EVL: if vm or mask bit i is 1, buffer element i = result element i; otherwise it keeps vd_old (mask-undisturbed).
  - For i >= EVL: keep vd_old (tail-undisturbed).
  - Mask bit i is bit i of the mask input, independent of SEW.
  - For mask ops each "element" is 1 bit. MERGE then handles LANE_SIZE*8 bits per cycle so a 256-bit mask completes in 16 cycles.
  - elem_idx advances by the step size; when elem_idx+step >= NE go to WRITE.
- Data-op MERGE latency = ceil(NE/LANE_SIZE) cycles: SEW8=16, SEW16=8, SEW32=4, SEW64=2.
- vl==0: skip MERGE entirely, go straight to WRITE with vd_old unchanged.
- WRITE: vrf_wr_valid=1 with index/data stable until vrf_wr_ready=1.
  - In the handshake cycle: clear valid, pulse wb_done and return to IDLE.
  - vrf_wr_ready while not valid is ignored.
- Overrun: FINISHED while state != IDLE sets overrun_err, held until reset; the in-flight transfer is unaffected.
- rdy_in=0 freezes state, elem_idx and buffers. vrf_wr_valid holds its value, and a ready arriving while rdy_in=0 is not consumed.
- Out-of-range cur_vsew (>3): treated as `EIGHT_BYTE and overrun_err is set.

Optional Feature:
- Macro: VECTOR_WB_TAIL_AGNOSTIC_EN.
- Defined: tail elements (i >= EVL) and masked-off elements are written all-ones (tail/mask-agnostic). MERGE still iterates the same cycle count.
- Undefined: undisturbed policy exactly as in Behaviour.

Test Plan:
- SEW32, vl=8, vm=1, result words 0..7 = 1..8, vd_old all 0xAAAAAAAA, ready held 1 -> vrf_wr_data words = 1..8; wb_done 1 cycle after WRITE entry; total FINISHED->wb_done = 6 cycles.
- SEW8, vl=5, vm=1, result all 0x11, vd_old all 0x00 -> bytes 0..4 = 0x11, bytes 5..31 = 0x00; with VECTOR_WB_TAIL_AGNOSTIC_EN, bytes 5..31 = 0xFF.
- SEW16, vl=16, vm=0, v0 = 0x5555, result all 0x1234, vd_old all 0xBEEF -> even halfwords 0x1234, odd halfwords 0xBEEF.
- is_mask=1, vl=10, vm=1, result bits 0..9 = 1, vd_old = 0 -> vrf_wr_data = 0x3FF in bits [9:0], rest 0; MERGE takes 16 cycles.
- vrf_wr_ready held 0 for 5 cycles, a second FINISHED pulsed during WRITE -> valid/data stable all 5 cycles, overrun_err=1, exactly one wb_done; then rst=0 mid-MERGE on a new op -> all outputs 0 immediately, no vrf_wr_valid.
- vl=0 -> no MERGE cycles, vrf_wr_data == vd_old, wb_done 2 cycles after FINISHED with ready=1.
